axis_tlast_framer: RTL and testbench
====================================

# axis_tlast_framer

Upstream framing stage for the AXI4-Stream slave input `A` of the HLS `example` core. It accepts a raw word stream on a simple valid/ready port and groups the words into packets of a programmable length. It drives `TDATA`, `TVALID`, `TKEEP`, `TSTRB` and `TLAST` with `TLAST` on each packet's final beat, and honours `TREADY` back-pressure at full throughput through a 2-entry skid buffer.

## Interface
Parameters:
- `DATA_W`, 32, data width in bits; must be a multiple of 8.
- `LEN_W`, 16, width of the packet-length configuration.

Ports:
- `ap_clk`  in  1  single clock; all logic is rising-edge.
- `ap_rst`  in  1  asynchronous, active-high reset.
- `cfg_len`  in  LEN_W  beats per packet; sampled on the first beat of each packet.
- `s_data`  in  DATA_W  raw input word.
- `s_valid`  in  1  `s_data` is valid.
- `s_ready`  out  1  framer can accept a word.
- `s_flush`  in  1  qualified by `s_valid`; forces the accepted word to close its packet.
- `M_TDATA`  out  DATA_W  stream data to `A_TDATA`.
- `M_TVALID`  out  1  stream valid.
- `M_TREADY`  in  1  downstream ready.
- `M_TKEEP`  out  DATA_W/8  always all ones.
- `M_TSTRB`  out  DATA_W/8  always all ones.
- `M_TLAST`  out  1  last beat of the packet.
- `pkt_count`  out  32  packets completed on the M side.
- `busy`  out  1  a packet is open, or the skid buffer is non-empty.

## Operation
- **Accept:** an input word is accepted when `s_valid && s_ready`. An output beat is transferred when `M_TVALID && M_TREADY`.
- **Framer FSM:** two states, `IDLE` and `RUN`.
  - `IDLE`, first word accepted: `len_q <= max(cfg_len, 1)` and `beat_cnt <= 1`. Go to `RUN` unless that word is last.
  - `RUN`, word accepted: `beat_cnt <= beat_cnt + 1`.
  - A word is last when its 1-based beat number equals the effective length, or when `s_flush` is high. After a last word, `beat_cnt <= 0` and the FSM returns to `IDLE`.
  - `cfg_len = 0` is treated as 1, so every word carries `TLAST`.
  - Changes to `cfg_len` while in `RUN` have no effect until the next packet.
  - `s_flush` in `IDLE` produces a 1-beat packet.
- **Skid buffer:** an output register plus one skid register, each holding `{data, last}`.
  - `s_ready = !skid_full`, driven from a register with no combinational path from `M_TREADY`.
  - Accept while output empty, or while output is transferring: the word goes to the output register.
  - Accept while output is stalled: the word goes to the skid register.
  - When output transfers and skid is full: skid moves to the output register and the skid register empties.
- **Counters and outputs:**
  - `pkt_count` increments on every transferred beat with `M_TLAST = 1` and wraps from `2^32-1` to 0.
  - `M_TKEEP` and `M_TSTRB` are constant all ones (full-word beats only).
- **Stability:** `M_TDATA` and `M_TLAST` must not change while `M_TVALID && !M_TREADY`.

## Timing
- **Reset values:**
  - `s_ready = 1` (reset deasserts into the accepting state).
  - `M_TVALID = 0`, `M_TLAST = 0`, `M_TDATA = 0`, `pkt_count = 0`, `busy = 0`.
  - FSM in `IDLE`, `beat_cnt = 0`, both buffer entries empty.
- **Latency:** 1 cycle from the input accept edge to `M_TVALID` high with that word.
- **Throughput:** 1 beat/cycle sustained while `M_TREADY = 1`.
- **Back-pressure:**
  - `M_TREADY` low for one or more cycles: at most 1 word goes into skid, then `s_ready` drops the following cycle.
  - `s_ready` reasserts the cycle after the skid entry drains.
- **Simultaneous events:** accept and transfer in the same cycle with skid empty leaves occupancy unchanged, with no bubble.
- **Reset mid-packet:** everything clears immediately (asynchronous). The partial packet is dropped, no `TLAST` is emitted for it, and the next accepted word starts a new packet.
- **Counter boundary:** `beat_cnt` is `LEN_W` bits wide. The maximum length `2^LEN_W - 1` must frame correctly with no overflow.

## Structure
- Shared package `axis_pkg`:
  - `axis_beat_t` struct `{data, last}`.
  - Constant `AXIS_KEEP_ALL` (all-ones keep/strobe).
  - FSM state enum `framer_state_e`.
- Sub-module `axis_skid_buf`: the 2-entry buffer, parameterised on beat width. It is reusable on the `B` side of the core.
- Top level holds the FSM, the beat counter, `len_q`, `pkt_count` and `busy`.

## Test plan
- **Basic framing:** `cfg_len = 4`, feed 12 words `0..11` with `M_TREADY = 1`.
  - Expect 12 beats, `TLAST` on words 3, 7 and 11.
  - `pkt_count = 3`; `M_TVALID` one cycle after each accept.
- **Length 0 and 1:** `cfg_len = 0`, feed 3 words → 3 beats all with `TLAST`, `pkt_count = 3`. Repeat with `cfg_len = 1` → same result.
- **Back-pressure:** `cfg_len = 5`, continuous `s_valid`, `M_TREADY` pattern 1,0,0,1,0,1…
  - Output sequence is exact and in order with no loss or duplication.
  - `s_ready` low within 1 cycle of a stall with skid full.
  - Data is stable during every stall.
- **Flush and config change:**
  - `cfg_len = 8`, `s_flush` on word 2 → `TLAST` on word 2.
  - Change `cfg_len` to 3 mid-packet → the current packet keeps its length; the next packet has 3 beats.
- **Reset mid-packet:** `cfg_len = 6`, assert `ap_rst` after 3 accepted words.
  - All outputs return to reset values in the same cycle.
  - After release, 6 new words give `TLAST` on the 6th and `pkt_count = 1`.
- **Counter wrap:** force `pkt_count` to `32'hFFFF_FFFF`, complete 1 packet → `pkt_count = 0`.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared AXI4-Stream framing types: beat layout, keep/strobe constant and framer states.
package axis_pkg;

    localparam int AXIS_DATA_W     = 32;
    localparam int AXIS_MAX_KEEP_W = 128;

    // Wide enough for any supported DATA_W; users slice the low DATA_W/8 bits.
    localparam logic [AXIS_MAX_KEEP_W-1:0] AXIS_KEEP_ALL = '1;

    typedef struct packed {
        logic [AXIS_DATA_W-1:0] data;
        logic                   last;
    } axis_beat_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } framer_state_e;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry skid buffer: output register plus one skid register, full throughput,
// s_ready registered so the upstream never sees a combinational path from m_ready.
module axis_skid_buf #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] s_beat,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [W-1:0] m_beat,
    output logic         m_valid,
    input  logic         m_ready,
    output logic         empty
);

    logic [W-1:0] out_q, skid_q;
    logic         out_vld_q, skid_vld_q;
    logic         push, pop;

    assign push = s_valid && !skid_vld_q;
    assign pop  = out_vld_q && m_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q      <= '0;
            skid_q     <= '0;
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
        end else if (push) begin
            // skid is empty whenever push is possible
            if (!out_vld_q || pop) begin
                out_q     <= s_beat;
                out_vld_q <= 1'b1;
            end else begin
                skid_q     <= s_beat;
                skid_vld_q <= 1'b1;
            end
        end else if (pop) begin
            if (skid_vld_q) begin
                out_q      <= skid_q;
                skid_vld_q <= 1'b0;
            end else begin
                out_vld_q  <= 1'b0;
            end
        end
    end

    assign s_ready = !skid_vld_q;
    assign m_beat  = out_q;
    assign m_valid = out_vld_q;
    assign empty   = !out_vld_q && !skid_vld_q;

endmodule

// File: rtl/axis_tlast_framer.sv
// Groups a raw valid/ready word stream into packets of cfg_len beats and drives
// an AXI4-Stream master with TLAST on each packet's final beat.
module axis_tlast_framer
    import axis_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    input  logic [LEN_W-1:0]    cfg_len,
    input  logic [DATA_W-1:0]   s_data,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic                s_flush,
    output logic [DATA_W-1:0]   M_TDATA,
    output logic                M_TVALID,
    input  logic                M_TREADY,
    output logic [DATA_W/8-1:0] M_TKEEP,
    output logic [DATA_W/8-1:0] M_TSTRB,
    output logic                M_TLAST,
    output logic [31:0]         pkt_count,
    output logic                busy
);

    localparam int BEAT_W = DATA_W + 1;

    framer_state_e    state_q, state_d;
    logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] eff_len, beat_num;
    logic             accept, is_last, buf_empty;
    logic [31:0]      pkt_count_q;

    assign accept = s_valid && s_ready;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            len_q      <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            len_q      <= len_d;
        end
    end

    // beat_num never exceeds len_q, so the maximum length cannot overflow beat_cnt.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        len_d      = len_q;
        eff_len    = len_q;
        beat_num   = beat_cnt_q + LEN_W'(1);
        if (state_q == IDLE) begin
            eff_len  = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
            beat_num = LEN_W'(1);
        end
        is_last = s_flush || (beat_num == eff_len);
        if (accept) begin
            len_d = eff_len;
            if (is_last) begin
                state_d    = IDLE;
                beat_cnt_d = '0;
            end else begin
                state_d    = RUN;
                beat_cnt_d = beat_num;
            end
        end
    end

    axis_skid_buf #(.W(BEAT_W)) u_skid (
        .clk     (ap_clk),
        .rst     (ap_rst),
        .s_beat  ({s_data, is_last}),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_beat  ({M_TDATA, M_TLAST}),
        .m_valid (M_TVALID),
        .m_ready (M_TREADY),
        .empty   (buf_empty)
    );

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst)
            pkt_count_q <= '0;
        else if (M_TVALID && M_TREADY && M_TLAST)
            pkt_count_q <= pkt_count_q + 32'd1;
    end

    assign pkt_count = pkt_count_q;
    assign busy      = (state_q == RUN) || !buf_empty;
    assign M_TKEEP   = AXIS_KEEP_ALL[DATA_W/8-1:0];
    assign M_TSTRB   = AXIS_KEEP_ALL[DATA_W/8-1:0];

endmodule

// File: tb/tb_axis_tlast_framer.sv
// Directed bench for axis_tlast_framer: a queue-based packet model checked every cycle,
// plus hand-computed expectations per scenario.
module tb_axis_tlast_framer;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 16;
    localparam int KW     = DATA_W / 8;

    logic              ap_clk = 0;
    logic              ap_rst = 0;
    logic [LEN_W-1:0]  cfg_len = '0;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_valid = 0;
    logic              s_ready;
    logic              s_flush = 0;
    logic [DATA_W-1:0] M_TDATA;
    logic              M_TVALID;
    logic              M_TREADY = 1;
    logic [KW-1:0]     M_TKEEP, M_TSTRB;
    logic              M_TLAST;
    logic [31:0]       pkt_count;
    logic              busy;

    axis_tlast_framer #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .cfg_len(cfg_len),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_flush(s_flush),
        .M_TDATA(M_TDATA), .M_TVALID(M_TVALID), .M_TREADY(M_TREADY),
        .M_TKEEP(M_TKEEP), .M_TSTRB(M_TSTRB), .M_TLAST(M_TLAST),
        .pkt_count(pkt_count), .busy(busy)
    );

    always #5 ap_clk = ~ap_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    typedef struct packed { logic [31:0] data; logic last; } exp_t;
    exp_t        q[$];
    exp_t        e;
    int          m_idx = 0;
    int          m_len = 1;
    logic [31:0] m_cnt = 0;
    int          occ;
    logic        lst;
    int          obs_n = 0;
    logic        obs_last[64];
    logic [31:0] obs_data[64];
    logic        prev_stall = 0;
    logic [31:0] prev_data;
    logic        prev_last;

    always @(negedge ap_clk) begin
        if (ap_rst) begin
            prev_stall = 0;
        end else begin
            occ = q.size();
            check("m_tvalid", M_TVALID, occ > 0);
            check("s_ready", s_ready, occ < 2);
            check("busy", busy, (occ > 0) || (m_idx != 0));
            check("pkt_count", pkt_count, m_cnt);
            check("keep_strb", {M_TKEEP, M_TSTRB}, 8'hFF);
            if (prev_stall) begin
                check("stall_data", M_TDATA, prev_data);
                check("stall_last", M_TLAST, prev_last);
            end
            if (M_TVALID && M_TREADY && occ > 0) begin
                e = q.pop_front();
                check("beat_data", M_TDATA, e.data);
                check("beat_last", M_TLAST, e.last);
                if (obs_n < 64) begin
                    obs_data[obs_n] = M_TDATA;
                    obs_last[obs_n] = M_TLAST;
                end
                obs_n++;
                if (e.last) m_cnt = m_cnt + 32'd1;
            end
            prev_stall = M_TVALID && !M_TREADY;
            prev_data  = M_TDATA;
            prev_last  = M_TLAST;
            if (s_valid && s_ready) begin
                if (m_idx == 0) m_len = (cfg_len == 0) ? 1 : int'(cfg_len);
                m_idx++;
                lst = s_flush || (m_idx == m_len);
                if (lst) m_idx = 0;
                q.push_back('{data: s_data, last: lst});
            end
        end
    end

    // ---------------- TREADY driver ----------------
    int tr_mode = 0;
    int tr_ph   = 0;
    logic [5:0] tr_pat = 6'b101001;  // bit0 first: 1,0,0,1,0,1

    always @(posedge ap_clk) begin
        #1;
        if (tr_mode == 1) begin
            M_TREADY = tr_pat[tr_ph];
            tr_ph = (tr_ph + 1) % 6;
        end else begin
            M_TREADY = (tr_mode == 0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [31:0] base, input int n, input int flush_at, input bit chk_lat);
        for (int i = 0; i < n; i++) begin
            int budget = 0;
            bit acc = 0;
            s_data  = base + i;
            s_flush = (i == flush_at);
            s_valid = 1;
            while (!acc) begin
                @(negedge ap_clk);
                acc = s_ready;
                @(posedge ap_clk);
                #1;
                budget++;
                if (!acc && budget > 200) begin
                    check("accept_timeout", 0, 1);
                    acc = 1;
                end
            end
            if (chk_lat) begin
                check("latency_valid", M_TVALID, 1);
                check("latency_data", M_TDATA, base + i);
            end
        end
        s_valid = 0;
        s_flush = 0;
    endtask

    task automatic drain();
        int budget = 0;
        while (q.size() != 0 && budget < 300) begin
            @(posedge ap_clk);
            #1;
            budget++;
        end
        if (q.size() != 0) check("drain_timeout", q.size(), 0);
        repeat (2) @(posedge ap_clk);
        #1;
    endtask

    function automatic int last_count();
        int c = 0;
        for (int i = 0; i < obs_n && i < 64; i++) if (obs_last[i]) c++;
        return c;
    endfunction

    initial begin
        // reset values
        #1 ap_rst = 1;
        #2;
        check("rst_s_ready", s_ready, 1);
        check("rst_tvalid", M_TVALID, 0);
        check("rst_tlast", M_TLAST, 0);
        check("rst_tdata", M_TDATA, 0);
        check("rst_pkt_count", pkt_count, 0);
        check("rst_busy", busy, 0);
        repeat (2) @(posedge ap_clk);
        #2 ap_rst = 0;
        @(posedge ap_clk);
        #1;

        // basic framing
        obs_n = 0;
        cfg_len = 4;
        send(0, 12, -1, 1);
        drain();
        check("basic_beats", obs_n, 12);
        check("basic_last3", obs_last[3], 1);
        check("basic_last7", obs_last[7], 1);
        check("basic_last11", obs_last[11], 1);
        check("basic_last_n", last_count(), 3);
        check("basic_data11", obs_data[11], 11);
        check("basic_pkts", pkt_count, 3);

        // length 0 then 1
        obs_n = 0;
        cfg_len = 0;
        send(100, 3, -1, 1);
        drain();
        check("len0_lasts", last_count(), 3);
        check("len0_pkts", pkt_count, 6);
        obs_n = 0;
        cfg_len = 1;
        send(110, 3, -1, 1);
        drain();
        check("len1_lasts", last_count(), 3);
        check("len1_pkts", pkt_count, 9);

        // back-pressure
        obs_n = 0;
        cfg_len = 5;
        tr_ph = 0;
        tr_mode = 1;
        send(200, 20, -1, 0);
        tr_mode = 0;
        drain();
        check("bp_beats", obs_n, 20);
        check("bp_data0", obs_data[0], 200);
        check("bp_data19", obs_data[19], 219);
        check("bp_last4", obs_last[4], 1);
        check("bp_last19", obs_last[19], 1);
        check("bp_last_n", last_count(), 4);
        check("bp_pkts", pkt_count, 13);

        // flush on word 2
        obs_n = 0;
        cfg_len = 8;
        send(300, 3, 2, 0);
        drain();
        check("flush_beats", obs_n, 3);
        check("flush_last1", obs_last[1], 0);
        check("flush_last2", obs_last[2], 1);
        check("flush_pkts", pkt_count, 14);

        // cfg_len change mid-packet
        obs_n = 0;
        cfg_len = 8;
        send(310, 2, -1, 0);
        cfg_len = 3;
        send(312, 6, -1, 0);
        send(320, 3, -1, 0);
        drain();
        check("cfg_beats", obs_n, 11);
        check("cfg_last2", obs_last[2], 0);
        check("cfg_last7", obs_last[7], 1);
        check("cfg_last10", obs_last[10], 1);
        check("cfg_last_n", last_count(), 2);
        check("cfg_pkts", pkt_count, 16);

        // reset mid-packet
        cfg_len = 6;
        send(400, 3, -1, 0);
        #1;
        ap_rst = 1;
        q.delete();
        m_idx = 0;
        m_cnt = 0;
        #1;
        check("mid_rst_tvalid", M_TVALID, 0);
        check("mid_rst_tlast", M_TLAST, 0);
        check("mid_rst_tdata", M_TDATA, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_s_ready", s_ready, 1);
        check("mid_rst_pkts", pkt_count, 0);
        #1 ap_rst = 0;
        @(posedge ap_clk);
        #1;
        obs_n = 0;
        send(410, 6, -1, 0);
        drain();
        check("post_rst_beats", obs_n, 6);
        check("post_rst_last4", obs_last[4], 0);
        check("post_rst_last5", obs_last[5], 1);
        check("post_rst_pkts", pkt_count, 1);

        // pkt_count wrap
        force dut.pkt_count_q = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        #1 release dut.pkt_count_q;
        #1 check("wrap_pre", pkt_count, 32'hFFFF_FFFF);
        cfg_len = 1;
        send(500, 1, -1, 0);
        drain();
        check("wrap_pkts", pkt_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
